// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
// Holds the state encoding, the registered output bundle and the counter-width helpers.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_PWRDN     = 3'd4
  } state_e;

  localparam int RELOCK_W = 8;

  typedef struct packed {
    logic pll_rst;
    logic pll_pwrdwn;
    logic rst_out;
    logic ready;
  } out_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int phase_width(input int pulse, input int stable);
    return cnt_width((pulse > stable) ? pulse : stable);
  endfunction

  function automatic out_t decode(input state_e s);
    out_t o;
    o = '{pll_rst: 1'b1, pll_pwrdwn: 1'b0, rst_out: 1'b1, ready: 1'b0};
    case (s)
      ST_RESET:     o = '{pll_rst: 1'b1, pll_pwrdwn: 1'b0, rst_out: 1'b1, ready: 1'b0};
      ST_WAIT_LOCK: o = '{pll_rst: 1'b0, pll_pwrdwn: 1'b0, rst_out: 1'b1, ready: 1'b0};
      ST_STABLE:    o = '{pll_rst: 1'b0, pll_pwrdwn: 1'b0, rst_out: 1'b1, ready: 1'b0};
      ST_RUN:       o = '{pll_rst: 1'b0, pll_pwrdwn: 1'b0, rst_out: 1'b0, ready: 1'b1};
      ST_PWRDN:     o = '{pll_rst: 1'b1, pll_pwrdwn: 1'b1, rst_out: 1'b1, ready: 1'b0};
      default:      o = '{pll_rst: 1'b1, pll_pwrdwn: 1'b0, rst_out: 1'b1, ready: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL LOCKED into the reference clock domain.
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_async,
  output logic o_sync
);

  // NOTE: no reset on the synchronizer chain; it carries no state that matters
  // and a reset here would only add a timing arc into the metastability flops.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Reset/lock sequencer for a PLL: pulses PLL RST, waits for stable lock, then
// releases downstream reset; re-pulses on lock loss or acquisition timeout.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOCKED_IN,
  input  logic                PWRDWN_REQ,
  output logic                PLL_RST,
  output logic                PLL_PWRDWN,
  output logic                RST_OUT,
  output logic                READY,
  output logic                TIMEOUT,
  output logic [RELOCK_W-1:0] RELOCK_CNT
);

  localparam int PW = phase_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES);
  localparam int TW = cnt_width(LOCK_TIMEOUT_CYCLES);

  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [PW-1:0] STABLE_LAST = PW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);

  if (RST_PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("pll_rst_seq: RST_PULSE_CYCLES must be >= 1");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
    $error("pll_rst_seq: LOCK_STABLE_CYCLES must be >= 1");
  end
  if (LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES) begin : g_bad_timeout
    $error("pll_rst_seq: LOCK_TIMEOUT_CYCLES must exceed LOCK_STABLE_CYCLES");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pll_rst_seq: SYNC_STAGES must be >= 2");
  end

  logic                w_lock_s;
  state_e              r_state,      w_state_nxt;
  logic [PW-1:0]       r_phase_cnt,  w_phase_nxt;
  logic [TW-1:0]       r_tmo_cnt,    w_tmo_nxt;
  logic                r_timeout,    w_timeout_nxt;
  logic [RELOCK_W-1:0] r_relock_cnt, w_relock_nxt;
  out_t                r_out,        w_out_nxt;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (CLK),
    .i_async (LOCKED_IN),
    .o_sync  (w_lock_s)
  );

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase_cnt;
    w_tmo_nxt     = r_tmo_cnt;
    w_timeout_nxt = r_timeout;
    w_relock_nxt  = r_relock_cnt;

    if (PWRDWN_REQ) begin
      w_state_nxt = ST_PWRDN;
      w_phase_nxt = '0;
      w_tmo_nxt   = '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_phase_cnt == PULSE_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt   = ST_RESET;
            w_phase_nxt   = '0;
            w_tmo_nxt     = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo_cnt + 1'b1;
            if (w_lock_s) begin
              w_state_nxt = ST_STABLE;
              w_phase_nxt = '0;
            end
          end
        end
        ST_STABLE: begin
          // Timeout outranks the release to RUN on the same cycle.
          if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt   = ST_RESET;
            w_phase_nxt   = '0;
            w_tmo_nxt     = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo_cnt + 1'b1;
            if (!w_lock_s) begin
              w_state_nxt = ST_WAIT_LOCK;
              w_phase_nxt = '0;
            end else if (r_phase_cnt == STABLE_LAST) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_phase_nxt = r_phase_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_state_nxt = ST_RESET;
            w_phase_nxt = '0;
            w_tmo_nxt   = '0;
            if (r_relock_cnt != '1) begin
              w_relock_nxt = r_relock_cnt + 1'b1;
            end
          end
        end
        ST_PWRDN: begin
          w_state_nxt = ST_RESET;
          w_phase_nxt = '0;
          w_tmo_nxt   = '0;
        end
        default: begin
          w_state_nxt = ST_RESET;
          w_phase_nxt = '0;
          w_tmo_nxt   = '0;
        end
      endcase
    end

    w_out_nxt = decode(w_state_nxt);
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_RESET;
      r_phase_cnt  <= '0;
      r_tmo_cnt    <= '0;
      r_timeout    <= 1'b0;
      r_relock_cnt <= '0;
      r_out        <= decode(ST_RESET);
    end else begin
      r_state      <= w_state_nxt;
      r_phase_cnt  <= w_phase_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_timeout    <= w_timeout_nxt;
      r_relock_cnt <= w_relock_nxt;
      r_out        <= w_out_nxt;
    end
  end

  assign PLL_RST    = r_out.pll_rst;
  assign PLL_PWRDWN = r_out.pll_pwrdwn;
  assign RST_OUT    = r_out.rst_out;
  assign READY      = r_out.ready;
  assign TIMEOUT    = r_timeout;
  assign RELOCK_CNT = r_relock_cnt;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, SYNC=2.
module tb_pll_rst_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOCKED_IN;
  logic       PWRDWN_REQ;
  logic       PLL_RST;
  logic       PLL_PWRDWN;
  logic       RST_OUT;
  logic       READY;
  logic       TIMEOUT;
  logic [7:0] RELOCK_CNT;

  int total = 0;
  int bad   = 0;

  pll_rst_seq #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .SYNC_STAGES         (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOCKED_IN  (LOCKED_IN),
    .PWRDWN_REQ (PWRDWN_REQ),
    .PLL_RST    (PLL_RST),
    .PLL_PWRDWN (PLL_PWRDWN),
    .RST_OUT    (RST_OUT),
    .READY      (READY),
    .TIMEOUT    (TIMEOUT),
    .RELOCK_CNT (RELOCK_CNT)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"},    PLL_RST,    1);
    check({tag, "_pll_pwrdwn"}, PLL_PWRDWN, 0);
    check({tag, "_rst_out"},    RST_OUT,    1);
    check({tag, "_ready"},      READY,      0);
    check({tag, "_timeout"},    TIMEOUT,    0);
    check({tag, "_relock"},     RELOCK_CNT, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: clean power-up with lock already present.
    RST = 1'b1; LOCKED_IN = 1'b1; PWRDWN_REQ = 1'b0;
    tick(3);
    check_reset_values("t1_rst");
    RST = 1'b0;
    tick(3);  check("t1_pll_rst_e3", PLL_RST, 1);
    tick(1);  check("t1_pll_rst_e4", PLL_RST, 0);
              check("t1_rst_out_e4", RST_OUT, 1);
    tick(8);  check("t1_rst_out_e12", RST_OUT, 1);
              check("t1_ready_e12", READY, 0);
    tick(1);  check("t1_rst_out_e13", RST_OUT, 0);
              check("t1_ready_e13", READY, 1);
              check("t1_timeout", TIMEOUT, 0);
              check("t1_relock", RELOCK_CNT, 0);

    // Scenario 5: power-down request from RUN, then re-acquisition.
    PWRDWN_REQ = 1'b1;
    tick(1);  check("t5_pwrdwn_on", PLL_PWRDWN, 1);
              check("t5_pll_rst_on", PLL_RST, 1);
              check("t5_rst_out_on", RST_OUT, 1);
              check("t5_ready_on", READY, 0);
    tick(9);  check("t5_pwrdwn_held", PLL_PWRDWN, 1);
    PWRDWN_REQ = 1'b0;
    tick(1);  check("t5_pwrdwn_off", PLL_PWRDWN, 0);
              check("t5_pll_rst_f1", PLL_RST, 1);
    tick(3);  check("t5_pll_rst_f4", PLL_RST, 1);
    tick(1);  check("t5_pll_rst_f5", PLL_RST, 0);
    tick(8);  check("t5_ready_f13", READY, 0);
    tick(1);  check("t5_ready_f14", READY, 1);
              check("t5_relock", RELOCK_CNT, 0);

    // Scenario 4a: two lock losses in RUN with recovery.
    for (int k = 1; k <= 2; k++) begin
      LOCKED_IN = 1'b0;
      tick(2);  check("t4_ready_g2", READY, 1);
      tick(1);  check("t4_ready_g3", READY, 0);
                check("t4_rst_out_g3", RST_OUT, 1);
                check("t4_pll_rst_g3", PLL_RST, 1);
                check("t4_relock_g3", RELOCK_CNT, k);
      LOCKED_IN = 1'b1;
      tick(12); check("t4_ready_g15", READY, 0);
      tick(1);  check("t4_ready_g16", READY, 1);
    end

    // Scenario 6 setup: third loss, lock stays away until timeout.
    LOCKED_IN = 1'b0;
    tick(3);  check("t6_relock_h3", RELOCK_CNT, 3);
              check("t6_pll_rst_h3", PLL_RST, 1);
    tick(4);  check("t6_pll_rst_h7", PLL_RST, 0);
    tick(63); check("t6_timeout_h70", TIMEOUT, 0);
              check("t6_pll_rst_h70", PLL_RST, 0);
    tick(1);  check("t6_timeout_h71", TIMEOUT, 1);
              check("t6_pll_rst_h71", PLL_RST, 1);
    tick(4);  check("t6_pll_rst_h75", PLL_RST, 0);
    tick(10); check("t6_timeout_wait", TIMEOUT, 1);
              check("t6_relock_wait", RELOCK_CNT, 3);
    RST = 1'b1;
    tick(1);
    check_reset_values("t6_rst");
    RST = 1'b0;

    // Scenario 2: no lock at all, periodic re-pulse every 68 cycles.
    tick(3);  check("t2_pll_rst_e3", PLL_RST, 1);
    tick(1);  check("t2_pll_rst_e4", PLL_RST, 0);
    tick(63); check("t2_pll_rst_e67", PLL_RST, 0);
              check("t2_timeout_e67", TIMEOUT, 0);
              check("t2_rst_out_e67", RST_OUT, 1);
    tick(1);  check("t2_pll_rst_e68", PLL_RST, 1);
              check("t2_timeout_e68", TIMEOUT, 1);
    tick(3);  check("t2_pll_rst_e71", PLL_RST, 1);
    tick(1);  check("t2_pll_rst_e72", PLL_RST, 0);
              check("t2_timeout_e72", TIMEOUT, 1);
    tick(63); check("t2_pll_rst_e135", PLL_RST, 0);
    tick(1);  check("t2_pll_rst_e136", PLL_RST, 1);
              check("t2_timeout_e136", TIMEOUT, 1);
              check("t2_rst_out_e136", RST_OUT, 1);

    // Scenario 3a: lock glitch during STABLE restarts the stable count.
    RST = 1'b1; LOCKED_IN = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(8);
    LOCKED_IN = 1'b0;
    tick(3);  check("t3_rst_out_e11", RST_OUT, 1);
    LOCKED_IN = 1'b1;
    tick(2);  check("t3_rst_out_e13", RST_OUT, 1);
              check("t3_ready_e13", READY, 0);
    tick(8);  check("t3_ready_e21", READY, 0);
              check("t3_rst_out_e21", RST_OUT, 1);
    tick(1);  check("t3_ready_e22", READY, 1);
              check("t3_timeout_e22", TIMEOUT, 0);

    // Scenario 3b: lock chattering with period 6 never settles; timeout at 64.
    RST = 1'b1; LOCKED_IN = 1'b1;
    tick(3);
    RST = 1'b0;
    for (int c = 0; c < 67; c++) begin
      LOCKED_IN = ((c % 6) < 3);
      tick(1);
    end
    check("t3c_timeout_e67", TIMEOUT, 0);
    check("t3c_ready_e67", READY, 0);
    check("t3c_pll_rst_e67", PLL_RST, 0);
    tick(1);
    check("t3c_timeout_e68", TIMEOUT, 1);
    check("t3c_pll_rst_e68", PLL_RST, 1);

    // Scenario 4b: 260 lock losses saturate RELOCK_CNT at 255.
    RST = 1'b1; LOCKED_IN = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(13); check("t4s_ready_start", READY, 1);
    for (int i = 1; i <= 260; i++) begin
      LOCKED_IN = 1'b0;
      tick(3);
      LOCKED_IN = 1'b1;
      tick(13);
      if (i == 254 || i == 255 || i == 260)
        check("t4s_relock", RELOCK_CNT, (i > 255) ? 255 : i);
    end
    check("t4s_ready_end", READY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
